ps2_scancode_decoder: RTL

Consumes raw PS/2 set-2 scan-code bytes from the keyboard receiver FIFO and turns them into key state. Pops one byte at a time over the receiver's `ready`/`nextdata_n` handshake, resolves `E0` (extended) and `F0` (break) prefixes, and tracks the single most recent held key. Presents that key's scan code, ASCII value, held flag and a press counter to the display and segment logic downstream.

---
 rtl/ps2_scancode_decoder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scancode_decoder
// Description : Pops PS/2 set-2 scan codes from the receiver FIFO, resolves
//               E0/F0 prefixes and tracks the most recently held key.
//               Optional macro: KBD_TYPEMATIC_FILTER_EN (drop repeated makes).
// Revision    : 1.0
// ============================================================================
module ps2_scancode_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_ready,
    output logic             kbd_nextdata_n,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic [7:0]       key_ascii,
    output logic             key_down,
    output logic [CNT_W-1:0] press_cnt,
    output logic             key_event
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_POP  = 2'd1;
    localparam logic [1:0] c_GAP  = 2'd2;

    localparam logic [7:0] c_CODE_EXT = 8'hE0;
    localparam logic [7:0] c_CODE_BRK = 8'hF0;

    logic [1:0] r_state;
    logic [7:0] r_byte;
    logic       r_ext_pend;
    logic       r_brk_pend;
    logic [7:0] w_ascii;
    logic       w_same_key;

    always_comb begin
        w_ascii = 8'h00;
        if (!r_ext_pend) begin
            case (r_byte)
                8'h1C: w_ascii = 8'h61; 8'h32: w_ascii = 8'h62; 8'h21: w_ascii = 8'h63;
                8'h23: w_ascii = 8'h64; 8'h24: w_ascii = 8'h65; 8'h2B: w_ascii = 8'h66;
                8'h34: w_ascii = 8'h67; 8'h33: w_ascii = 8'h68; 8'h43: w_ascii = 8'h69;
                8'h3B: w_ascii = 8'h6A; 8'h42: w_ascii = 8'h6B; 8'h4B: w_ascii = 8'h6C;
                8'h3A: w_ascii = 8'h6D; 8'h31: w_ascii = 8'h6E; 8'h44: w_ascii = 8'h6F;
                8'h4D: w_ascii = 8'h70; 8'h15: w_ascii = 8'h71; 8'h2D: w_ascii = 8'h72;
                8'h1B: w_ascii = 8'h73; 8'h2C: w_ascii = 8'h74; 8'h3C: w_ascii = 8'h75;
                8'h2A: w_ascii = 8'h76; 8'h1D: w_ascii = 8'h77; 8'h22: w_ascii = 8'h78;
                8'h35: w_ascii = 8'h79; 8'h1A: w_ascii = 8'h7A;
                8'h45: w_ascii = 8'h30; 8'h16: w_ascii = 8'h31; 8'h1E: w_ascii = 8'h32;
                8'h26: w_ascii = 8'h33; 8'h25: w_ascii = 8'h34; 8'h2E: w_ascii = 8'h35;
                8'h36: w_ascii = 8'h36; 8'h3D: w_ascii = 8'h37; 8'h3E: w_ascii = 8'h38;
                8'h46: w_ascii = 8'h39;
                8'h29: w_ascii = 8'h20; 8'h5A: w_ascii = 8'h0D;
                default: w_ascii = 8'h00;
            endcase
        end
    end

    // Identity of a key includes its E0 prefix: 75 and E0 75 are distinct keys.
    assign w_same_key = key_down && (r_byte == key_code) && (r_ext_pend == key_ext);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state        <= c_IDLE;
            r_byte         <= 8'h00;
            r_ext_pend     <= 1'b0;
            r_brk_pend     <= 1'b0;
            kbd_nextdata_n <= 1'b1;
            key_code       <= 8'h00;
            key_ext        <= 1'b0;
            key_ascii      <= 8'h00;
            key_down       <= 1'b0;
            press_cnt      <= '0;
            key_event      <= 1'b0;
        end else begin
            key_event <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (kbd_ready) begin
                        r_byte         <= kbd_data;
                        kbd_nextdata_n <= 1'b0;
                        r_state        <= c_POP;
                    end
                end
                c_POP: begin
                    kbd_nextdata_n <= 1'b1;
                    r_state        <= c_GAP;
                    if (r_byte == c_CODE_EXT) begin
                        r_ext_pend <= 1'b1;
                    end else if (r_byte == c_CODE_BRK) begin
                        r_brk_pend <= 1'b1;
                    end else begin
                        r_ext_pend <= 1'b0;
                        r_brk_pend <= 1'b0;
                        if (r_brk_pend) begin
                            if (w_same_key) begin
                                key_down  <= 1'b0;
                                key_code  <= 8'h00;
                                key_ascii <= 8'h00;
                                key_ext   <= 1'b0;
                            end
                        end else if (w_same_key) begin
`ifdef KBD_TYPEMATIC_FILTER_EN
                            key_event <= 1'b0;
`else
                            press_cnt <= press_cnt + 1'b1;
                            key_event <= 1'b1;
`endif
                        end else begin
                            key_code  <= r_byte;
                            key_ext   <= r_ext_pend;
                            key_ascii <= w_ascii;
                            key_down  <= 1'b1;
                            press_cnt <= press_cnt + 1'b1;
                            key_event <= 1'b1;
                        end
                    end
                end
                c_GAP: begin
                    kbd_nextdata_n <= 1'b1;
                    r_state        <= c_IDLE;
                end
                default: begin
                    kbd_nextdata_n <= 1'b1;
                    r_state        <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
